// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - shared constants and types for the HI/LO multiply/divide unit
//
// Holds the R-type funct codes recognised by the unit, the FSM state
// encoding, the iteration count and a helper that classifies a funct code.
package hilo_muldiv_pkg;

   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam int ITER_COUNT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic logic is_muldiv_funct(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/hilo_muldiv_iter.sv
// rtl/hilo_muldiv_iter.sv - unsigned 32-step shift-add multiplier / restoring divider
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   load           capture op_a/op_b and the operation kind
//   step           perform one iteration (one multiplier bit / one quotient bit)
//   is_div         operation kind sampled on load (1 = divide)
//   op_a, op_b     unsigned magnitudes: multiplicand/multiplier or dividend/divisor
//   result         multiply: 64-bit product; divide: {remainder, quotient}
module muldiv_iter
   import hilo_muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic        is_div,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [63:0] result
);

   logic [63:0] acc_q, acc_d;
   logic [31:0] m_q, m_d;
   logic        div_q, div_d;

   logic [32:0] sum;
   logic [32:0] rem_sh;
   logic [32:0] diff;

   always_comb begin
      acc_d = acc_q;
      m_d   = m_q;
      div_d = div_q;

      // Multiply: add the multiplicand into the upper half when the current
      // multiplier bit (acc[0]) is set, then shift the whole pair right.
      sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);

      // Divide: shift the remainder:quotient pair left by one; the remainder
      // can momentarily need 33 bits before the trial subtraction.
      rem_sh = acc_q[63:31];
      diff   = rem_sh - {1'b0, m_q};

      if (load) begin
         div_d = is_div;
         if (is_div) begin
            acc_d = {32'd0, op_a};
            m_d   = op_b;
         end else begin
            acc_d = {32'd0, op_b};
            m_d   = op_a;
         end
      end else if (step) begin
         if (div_q) begin
            if (rem_sh >= {1'b0, m_q}) begin
               acc_d = {diff[31:0], acc_q[30:0], 1'b1};
            end else begin
               acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end
         end else begin
            acc_d = {sum, acc_q[31:1]};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= 64'd0;
         m_q   <= 32'd0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         m_q   <= m_d;
         div_q <= div_d;
      end
   end

   assign result = acc_q;

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - multi-cycle mult/div unit with architectural HI/LO registers
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle request, honoured only in IDLE with a mult/div funct
//   Function_opcode       R-type funct (mult, multu, div, divu)
//   Read_data_1/2         rs / rt operands, sampled only at the accept edge
//   Mthi, Mtlo            write Read_data_1 into HI / LO while idle
//   busy                  operation in progress
//   done                  one-cycle pulse, HI/LO already hold the result
//   div_zero              last divide had a zero divisor; cleared at next accepted start
//   HI_out, LO_out        HI / LO registers
module hilo_muldiv
   import hilo_muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  Function_opcode,
   input  logic [31:0] Read_data_1,
   input  logic [31:0] Read_data_2,
   input  logic        Mthi,
   input  logic        Mtlo,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out
);

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;
   logic        div_zero_q, div_zero_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        zero_div_q, zero_div_d;
   logic [31:0] rs_q, rs_d;

   logic        accept;
   logic        is_signed;
   logic [31:0] abs_a, abs_b;
   logic        iter_load, iter_step;
   logic [63:0] iter_result;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   muldiv_iter u_iter (
      .clock  (clock),
      .reset  (reset),
      .load   (iter_load),
      .step   (iter_step),
      .is_div (Function_opcode[1]),
      .op_a   (abs_a),
      .op_b   (abs_b),
      .result (iter_result)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      zero_div_d = zero_div_q;
      rs_d       = rs_q;
      iter_load  = 1'b0;
      iter_step  = 1'b0;

      accept    = (state_q == IDLE) && start && is_muldiv_funct(Function_opcode);
      // funct bit 0 clear selects the signed variants (mult, div).
      is_signed = ~Function_opcode[0];
      abs_a     = (is_signed && Read_data_1[31]) ? -Read_data_1 : Read_data_1;
      abs_b     = (is_signed && Read_data_2[31]) ? -Read_data_2 : Read_data_2;

      prod_fix = neg_res_q ? -iter_result : iter_result;
      quo_fix  = neg_res_q ? -iter_result[31:0] : iter_result[31:0];
      rem_fix  = neg_rem_q ? -iter_result[63:32] : iter_result[63:32];

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = RUN;
               count_d    = 5'(ITER_COUNT - 1);
               iter_load  = 1'b1;
               is_div_d   = Function_opcode[1];
               neg_res_d  = is_signed && (Read_data_1[31] ^ Read_data_2[31]);
               neg_rem_d  = is_signed && Read_data_1[31];
               zero_div_d = Function_opcode[1] && (Read_data_2 == 32'd0);
               rs_d       = Read_data_1;
               div_zero_d = 1'b0;
            end else begin
               // A move in the same cycle as an accepted start is dropped.
               if (Mthi) hi_d = Read_data_1;
               if (Mtlo) lo_d = Read_data_1;
            end
         end
         RUN: begin
            iter_step = 1'b1;
            count_d   = count_q - 5'd1;
            if (count_q == 5'd0) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) begin
               if (zero_div_q) begin
                  lo_d       = 32'hFFFF_FFFF;
                  hi_d       = rs_q;
                  div_zero_d = 1'b1;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= 5'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         zero_div_q <= 1'b0;
         rs_q       <= 32'd0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         zero_div_q <= zero_div_d;
         rs_q       <= rs_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign HI_out   = hi_q;
   assign LO_out   = lo_q;

endmodule
